scratch_ram_stack: RTL and testbench
====================================

# scratch_ram_stack

Parametrised scratch memory for the RAT MCU, replacing the fixed 256×10 scratch RAM. It adds a hardware stack pointer with PUSH/POP, occupancy flags and a sticky error flag. It also clears the whole array in hardware after reset, since initial blocks do not clear it on the board. It sits between the control unit and the SCR_DATA mux, and keeps the existing SCR_ADDR/SCR_WE random-access path.

## Interface
- DATA_W, 10, word width
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- DATA_IN  in  DATA_W  write data for SCR_WE and PUSH
- SCR_ADDR  in  ADDR_W  random-access address
- SCR_WE  in  1  random-access write enable
- PUSH  in  1  push DATA_IN
- POP  in  1  pop top of stack
- DATA_OUT  out  DATA_W  read data (combinational)
- SP_OUT  out  ADDR_W  current stack pointer
- EMPTY  out  1  stack count == 0
- FULL  out  1  stack count == DEPTH
- BUSY  out  1  hardware clear in progress
- ERR  out  1  sticky: overflow, underflow or PUSH&POP together

## Operation
- States: CLEAR, READY (enum in package).
- RST (any state) -> state=CLEAR, clr_addr=0, SP=0, count=0, ERR=0.
- CLEAR: each cycle writes ram[clr_addr]=0 and increments clr_addr. Once clr_addr==DEPTH-1 has been written -> READY.
  - All PUSH/POP/SCR_WE are ignored. They do not set ERR.
  - DATA_OUT=0.
- READY: request priority per cycle:
  - PUSH&POP both high: no memory or SP change; ERR<=1.
  - PUSH only:
    - count==DEPTH: ignored, ERR<=1.
    - Otherwise: ram[SP-1]<=DATA_IN, SP<=SP-1 (mod DEPTH), count++.
  - POP only:
    - count==0: ignored, ERR<=1.
    - Otherwise: SP<=SP+1 (mod DEPTH), count--.
  - Neither, SCR_WE=1: ram[SCR_ADDR]<=DATA_IN.
  - SCR_WE is ignored whenever PUSH or POP is high. This is not an error.
- Read address = POP ? SP : SCR_ADDR. DATA_OUT = ram[read address], asynchronous.
  - POP therefore presents the top-of-stack value in the same cycle it is asserted.
- count is ADDR_W+1 bits wide. SP wraps: first PUSH from SP=0 writes address DEPTH-1.
- Random writes may alias stack contents. This is not checked.

## Timing
- Reset values: SP_OUT=0, EMPTY=1, FULL=0, BUSY=1, ERR=0, DATA_OUT=0.
- BUSY is high for exactly DEPTH cycles after the reset edge. The first accepted request is on the edge DEPTH+1 after reset.
- RST asserted mid-clear restarts the clear at address 0.
- Write and SP/count/flag updates take effect at the rising edge. SP_OUT, EMPTY, FULL and ERR are registered (flags may be registered or decoded from count, but must agree with count on the cycle following the edge).
- DATA_OUT reflects a write from the edge onward (read-after-write on the next cycle). There is no same-cycle bypass.
- ERR clears only on RST.

## Structure
- Package scratch_pkg holds:
  - typedef enum {CLEAR, READY} scr_state_t
  - localparam defaults DATA_W=10, ADDR_W=8
- Sub-module scratch_mem(DATA_W, ADDR_W): one synchronous write port, one asynchronous read port, no reset.
- Top level holds the FSM, clr_addr, SP, count, flag logic and the address/data/write-enable muxes. Write data is forced to 0 in CLEAR.

## Test plan
- Reset, then hold idle for DEPTH cycles:
  - BUSY=1 for 256 cycles, then 0.
  - SCR_ADDR sweep 0..255 reads 0 everywhere.
  - SCR_WE pulsed during CLEAR has no effect.
- SCR_WE=1, SCR_ADDR=0x2A, DATA_IN=0x3FF, then read 0x2A -> DATA_OUT=0x3FF next cycle, EMPTY stays 1.
- PUSH 0x001, 0x002, 0x003:
  - SP_OUT=0xFD, ram[0xFF]=0x001.
  - POP×3 -> DATA_OUT=0x003, 0x002, 0x001 in the POP cycles; SP_OUT back to 0, EMPTY=1, ERR=0.
- POP while EMPTY -> SP_OUT stays 0, ERR=1 and stays 1 until RST.
- 256 PUSHes -> FULL=1, SP_OUT=0. A 257th PUSH is ignored (ram[0xFF] unchanged) and sets ERR=1.
- PUSH&POP together with SCR_WE=1, SCR_ADDR=5 -> no memory or SP change, ERR=1. RST mid-clear at cycle 100 -> BUSY stays high 256 more cycles.

Source files
------------

// File: rtl/scratch_pkg.sv
// Shared types and default geometry for the RAT MCU scratch RAM with hardware stack.
// Pure declarations; no logic, no latency, no flow control.
package scratch_pkg;

   typedef enum logic {CLEAR, READY} scr_state_t;

   localparam int DEF_DATA_W = 10;
   localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/scratch_mem.sv
// Scratch storage array: one synchronous write port, one asynchronous read port, no reset.
// Write lands on the rising edge; read is combinational; always accepts.
module scratch_mem
   import scratch_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/scratch_ram_stack.sv
// Scratch RAM with descending hardware stack, occupancy flags, sticky error and post-reset clear.
// Updates on the rising edge, combinational read; every request is dropped while BUSY.
module scratch_ram_stack
   import scratch_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic [ADDR_W-1:0] SCR_ADDR,
   input  logic              SCR_WE,
   input  logic              PUSH,
   input  logic              POP,
   output logic [DATA_W-1:0] DATA_OUT,
   output logic [ADDR_W-1:0] SP_OUT,
   output logic              EMPTY,
   output logic              FULL,
   output logic              BUSY,
   output logic              ERR
);

   localparam int DEPTH = 2**ADDR_W;

   scr_state_t        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [ADDR_W-1:0] sp_q, sp_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              err_q, err_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [ADDR_W-1:0] mem_raddr;
   logic [DATA_W-1:0] mem_rdata;
   logic              empty, full;

   assign empty = (count_q == '0);
   assign full  = (count_q == (ADDR_W+1)'(DEPTH));

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      sp_d       = sp_q;
      count_d    = count_q;
      err_d      = err_q;
      mem_we     = 1'b0;
      mem_waddr  = SCR_ADDR;
      mem_wdata  = DATA_IN;
      case (state_q)
         CLEAR: begin
            mem_we     = 1'b1;
            mem_waddr  = clr_addr_q;
            mem_wdata  = '0;
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = READY;
            end
         end
         READY: begin
            if (PUSH && POP) begin
               err_d = 1'b1;
            end else if (PUSH) begin
               if (full) begin
                  err_d = 1'b1;
               end else begin
                  // Stack grows downward: pre-decrement, so the first push lands at DEPTH-1.
                  mem_we    = 1'b1;
                  mem_waddr = sp_q - ADDR_W'(1);
                  sp_d      = sp_q - ADDR_W'(1);
                  count_d   = count_q + (ADDR_W+1)'(1);
               end
            end else if (POP) begin
               if (empty) begin
                  err_d = 1'b1;
               end else begin
                  sp_d    = sp_q + ADDR_W'(1);
                  count_d = count_q - (ADDR_W+1)'(1);
               end
            end else if (SCR_WE) begin
               mem_we = 1'b1;
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
         sp_q       <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         sp_q       <= sp_d;
         count_q    <= count_d;
         err_q      <= err_d;
      end
   end

   // POP reads the current top of stack in the same cycle it is asserted.
   assign mem_raddr = POP ? sp_q : SCR_ADDR;

   scratch_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (CLK),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   assign DATA_OUT = (state_q == CLEAR) ? '0 : mem_rdata;
   assign SP_OUT   = sp_q;
   assign EMPTY    = empty;
   assign FULL     = full;
   assign BUSY     = (state_q == CLEAR);
   assign ERR      = err_q;

endmodule

// File: tb/tb_scratch_ram_stack.sv
// Directed bench for scratch_ram_stack: a stack-depth/array model checked every cycle plus literal pins.
module tb_scratch_ram_stack;

   localparam int DW    = 10;
   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          CLK = 1'b0;
   logic          RST;
   logic [DW-1:0] DATA_IN;
   logic [AW-1:0] SCR_ADDR;
   logic          SCR_WE, PUSH, POP;
   logic [DW-1:0] DATA_OUT;
   logic [AW-1:0] SP_OUT;
   logic          EMPTY, FULL, BUSY, ERR;

   int vectors     = 0;
   int miscompares = 0;

   scratch_ram_stack #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .SCR_ADDR(SCR_ADDR),
      .SCR_WE(SCR_WE), .PUSH(PUSH), .POP(POP), .DATA_OUT(DATA_OUT),
      .SP_OUT(SP_OUT), .EMPTY(EMPTY), .FULL(FULL), .BUSY(BUSY), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   // Model: the stack is just a depth n; its pointer is -n mod DEPTH.
   logic [DW-1:0] mram [DEPTH];
   int  n          = 0;
   int  busy_left  = 0;
   bit  merr       = 0;
   bit  model_valid = 0;

   function automatic int msp();
      return (DEPTH - n) % DEPTH;
   endfunction

   always @(posedge CLK) begin
      if (RST === 1'b1) begin
         model_valid = 1;
         busy_left   = DEPTH;
         n           = 0;
         merr        = 0;
         for (int i = 0; i < DEPTH; i++) mram[i] = '0;
      end else if (model_valid) begin
         if (busy_left > 0) begin
            busy_left--;
         end else if (PUSH && POP) begin
            merr = 1;
         end else if (PUSH) begin
            if (n == DEPTH) merr = 1;
            else begin
               mram[(DEPTH - n - 1) % DEPTH] = DATA_IN;
               n++;
            end
         end else if (POP) begin
            if (n == 0) merr = 1;
            else n--;
         end else if (SCR_WE) begin
            mram[SCR_ADDR] = DATA_IN;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (model_valid) begin
         logic [DW-1:0] exp_do;
         exp_do = (busy_left > 0) ? '0 : mram[POP ? AW'(msp()) : SCR_ADDR];
         chk("model SP_OUT", 32'(SP_OUT), 32'(msp()));
         chk("model EMPTY",  32'(EMPTY),  32'(n == 0));
         chk("model FULL",   32'(FULL),   32'(n == DEPTH));
         chk("model BUSY",   32'(BUSY),   32'(busy_left > 0));
         chk("model ERR",    32'(ERR),    32'(merr));
         chk("model DATA_OUT", 32'(DATA_OUT), 32'(exp_do));
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      PUSH = 0; POP = 0; SCR_WE = 0;
   endtask

   task automatic do_reset();
      RST = 1;
      step();
      RST = 0;
   endtask

   task automatic wait_clear(input string nm);
      int c = 0;
      while (BUSY === 1'b1 && c < 1000) begin
         step();
         c++;
      end
      chk(nm, 32'(c), 32'd256);
   endtask

   task automatic rd(input string nm, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      SCR_ADDR = a;
      #1;
      chk(nm, 32'(DATA_OUT), 32'(exp));
   endtask

   initial begin
      int c;
      RST = 1; DATA_IN = '0; SCR_ADDR = '0;
      idle();
      step();
      step();
      RST = 0;
      #1;
      chk("reset BUSY", 32'(BUSY), 32'd1);
      chk("reset SP_OUT", 32'(SP_OUT), 32'd0);
      chk("reset EMPTY", 32'(EMPTY), 32'd1);
      chk("reset FULL", 32'(FULL), 32'd0);
      chk("reset ERR", 32'(ERR), 32'd0);
      chk("reset DATA_OUT", 32'(DATA_OUT), 32'd0);

      // Requests thrown at the array during the clear must be dropped silently.
      c = 0;
      while (BUSY === 1'b1 && c < 1000) begin
         SCR_WE   = c[0];
         SCR_ADDR = AW'(c);
         DATA_IN  = 10'h3FF;
         PUSH     = (c == 10) || (c == 30);
         POP      = (c == 20) || (c == 30);
         step();
         c++;
      end
      idle();
      chk("clear length", 32'(c), 32'd256);
      #1;
      chk("post-clear ERR", 32'(ERR), 32'd0);
      for (int a = 0; a < DEPTH; a++) rd("sweep zero", AW'(a), 10'h000);

      SCR_ADDR = 8'h2A; DATA_IN = 10'h3FF; SCR_WE = 1;
      step();
      SCR_WE = 0;
      rd("raw 2A", 8'h2A, 10'h3FF);
      chk("raw EMPTY", 32'(EMPTY), 32'd1);

      for (int k = 1; k <= 3; k++) begin
         PUSH = 1; DATA_IN = DW'(k);
         step();
      end
      idle();
      #1;
      chk("push3 SP_OUT", 32'(SP_OUT), 32'hFD);
      rd("push3 ram FF", 8'hFF, 10'h001);
      rd("push3 ram FD", 8'hFD, 10'h003);

      SCR_ADDR = 8'h2A;
      for (int k = 3; k >= 1; k--) begin
         POP = 1;
         #1;
         chk("pop DATA_OUT", 32'(DATA_OUT), 32'(k));
         step();
      end
      idle();
      #1;
      chk("pop3 SP_OUT", 32'(SP_OUT), 32'd0);
      chk("pop3 EMPTY", 32'(EMPTY), 32'd1);
      chk("pop3 ERR", 32'(ERR), 32'd0);

      POP = 1;
      step();
      idle();
      #1;
      chk("underflow SP_OUT", 32'(SP_OUT), 32'd0);
      chk("underflow ERR", 32'(ERR), 32'd1);
      repeat (5) step();
      chk("ERR sticky", 32'(ERR), 32'd1);

      do_reset();
      wait_clear("clear after reset 2");
      for (int i = 0; i < DEPTH; i++) begin
         PUSH = 1; DATA_IN = DW'((i * 3 + 1) & 10'h3FF);
         step();
      end
      idle();
      #1;
      chk("fill FULL", 32'(FULL), 32'd1);
      chk("fill SP_OUT", 32'(SP_OUT), 32'd0);
      chk("fill ERR", 32'(ERR), 32'd0);
      rd("fill ram FF", 8'hFF, 10'h001);
      rd("fill ram 00", 8'h00, 10'h2FE);
      PUSH = 1; DATA_IN = 10'h155;
      step();
      idle();
      #1;
      chk("overflow ERR", 32'(ERR), 32'd1);
      chk("overflow FULL", 32'(FULL), 32'd1);
      rd("overflow ram FF", 8'hFF, 10'h001);

      do_reset();
      wait_clear("clear after reset 3");
      SCR_ADDR = 8'h05; DATA_IN = 10'h0AA; SCR_WE = 1;
      step();
      PUSH = 1; POP = 1; SCR_WE = 1; DATA_IN = 10'h123;
      step();
      idle();
      #1;
      chk("pushpop SP_OUT", 32'(SP_OUT), 32'd0);
      chk("pushpop EMPTY", 32'(EMPTY), 32'd1);
      chk("pushpop ERR", 32'(ERR), 32'd1);
      rd("pushpop ram 05", 8'h05, 10'h0AA);
      rd("pushpop ram FF", 8'hFF, 10'h000);

      do_reset();
      repeat (100) step();
      chk("mid-clear BUSY", 32'(BUSY), 32'd1);
      do_reset();
      wait_clear("restarted clear");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
